// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
//   master: drives start, a, b, cin; observes sum, cout, busy, done.
//   slave : the adder side of the same signals.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, cin,
        input  sum, cout, busy, done
    );

    modport slave (
        input  start, a, b, cin,
        output sum, cout, busy, done
    );

endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell resolves one bit per clock,
// LSB first, with a registered carry. {cout, sum} = a + b + cin after WIDTH
// RUN cycles, flagged by a one-cycle done pulse.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : slave side of serial_adder_if (start/a/b/cin in, sum/cout/busy/done out)
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Single full-adder cell on the current LSBs.
    logic s_bit;
    logic carry_nxt;

    always_comb begin
        s_bit     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = carry_nxt;
                // New bit enters at the MSB so the LSB-first stream lands in order.
                res_d   = (res_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
                if (cnt_q == LAST_BIT) begin
                    // Counter holds on the final edge so it never wraps.
                    sum_d   = res_d;
                    cout_d  = carry_nxt;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    bit   overlap;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // busy and done must never be high together on either instance.
    always @(negedge clk) begin
        if ((if8.busy && if8.done) || (if1.busy && if1.done)) overlap = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one WIDTH=8 operation; returns at the negedge where done is seen.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       output logic [7:0] s, output logic c,
                       output int busy_cycles, output bit got_done);
        @(negedge clk);
        if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = cin;
        @(negedge clk);
        // Scramble inputs after acceptance; they must be ignored.
        if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom); if8.cin = 1'($urandom);
        busy_cycles = 0; got_done = 1'b0; s = 'x; c = 1'bx;
        for (int i = 0; i < 40 && !got_done; i++) begin
            if (if8.busy) busy_cycles++;
            if (if8.done) begin
                got_done = 1'b1; s = if8.sum; c = if8.cout;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic op1(input logic a, input logic b, input logic cin,
                       output logic s, output logic c,
                       output int busy_cycles, output bit got_done);
        @(negedge clk);
        if1.start = 1'b1; if1.a = a; if1.b = b; if1.cin = cin;
        @(negedge clk);
        if1.start = 1'b0; if1.a = 1'($urandom); if1.b = 1'($urandom); if1.cin = 1'($urandom);
        busy_cycles = 0; got_done = 1'b0; s = 1'bx; c = 1'bx;
        for (int i = 0; i < 10 && !got_done; i++) begin
            if (if1.busy) busy_cycles++;
            if (if1.done) begin
                got_done = 1'b1; s = if1.sum; c = if1.cout;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [7:0] s8;
        logic       c8;
        logic       s1;
        logic       c1;
        int         bc;
        bit         gd;
        bit         flag;
        bit         hold_ok;
        int         n;
        logic [7:0] ra, rb, diff;
        logic       rc;
        logic [8:0] exp9;
        logic [1:0] exp2;

        tests = 0; fails = 0; overlap = 1'b0;
        rst = 1'b1;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_sum8",  32'(if8.sum),  32'h0);
        check("rst_cout8", 32'(if8.cout), 32'h0);
        check("rst_busy8", 32'(if8.busy), 32'h0);
        check("rst_done8", 32'(if8.done), 32'h0);
        check("rst_busy1", 32'(if1.busy), 32'h0);

        // Basic add with busy length and single-cycle done
        op8(8'h0F, 8'h01, 1'b0, s8, c8, bc, gd);
        check("basic_done", 32'(gd), 32'h1);
        check("basic_busy_len", 32'(bc), 32'd8);
        check("basic_sum", 32'(s8), 32'h10);
        check("basic_cout", 32'(c8), 32'h0);
        @(negedge clk);
        check("basic_done_pulse", 32'(if8.done), 32'h0);
        check("basic_sum_hold", 32'(if8.sum), 32'h10);

        // Carry-out / carry-in corners
        op8(8'hFF, 8'h01, 1'b0, s8, c8, bc, gd);
        check("ff01", 32'({gd, c8, s8}), 32'h300);
        op8(8'h00, 8'h00, 1'b1, s8, c8, bc, gd);
        check("0000c", 32'({gd, c8, s8}), 32'h201);
        op8(8'hFF, 8'hFF, 1'b1, s8, c8, bc, gd);
        check("ffffc", 32'({gd, c8, s8}), 32'h3FF);

        // start ignored while busy; sum holds prior 8'hFF until done
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b0;
        @(negedge clk);
        if8.start = 1'b0;
        hold_ok = 1'b1; flag = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (!if8.busy || if8.done) flag = 1'b0;
            if (if8.sum !== 8'hFF || if8.cout !== 1'b1) hold_ok = 1'b0;
            if (i == 3) begin
                if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF;
            end else begin
                if8.start = 1'b0;
            end
            @(negedge clk);
        end
        if8.start = 1'b0;
        check("ign_busy8", 32'(flag), 32'h1);
        check("ign_hold", 32'(hold_ok), 32'h1);
        check("ign_done", 32'(if8.done), 32'h1);
        check("ign_sum", 32'({if8.cout, if8.sum}), 32'h046);
        flag = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done || if8.busy) flag = 1'b1;
        end
        check("ign_no_second", 32'(flag), 32'h0);

        // Back-to-back: start during the DONE cycle
        op8(8'h01, 8'h02, 1'b0, s8, c8, bc, gd);
        check("b2b_first", 32'({gd, c8, s8}), 32'h203);
        if8.start = 1'b1; if8.a = 8'h80; if8.b = 8'h80; if8.cin = 1'b0;
        @(negedge clk);
        if8.start = 1'b0;
        n = 1;
        check("b2b_busy_rise", 32'(if8.busy), 32'h1);
        while (!if8.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_gap", 32'(n), 32'd9);
        check("b2b_sum", 32'({if8.cout, if8.sum}), 32'h100);

        // Reset mid-operation (RUN cycle 4)
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h0F; if8.b = 8'h01; if8.cin = 1'b0;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_state", 32'({if8.busy, if8.done, if8.cout, if8.sum}), 32'h0);
        flag = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (if8.done || if8.busy) flag = 1'b1;
        end
        check("mid_rst_no_done", 32'(flag), 32'h0);
        op8(8'h33, 8'h44, 1'b1, s8, c8, bc, gd);
        check("after_rst", 32'({gd, c8, s8}), 32'h278);

        // WIDTH=1 directed
        op1(1'b1, 1'b1, 1'b1, s1, c1, bc, gd);
        check("w1_111", 32'({gd, c1, s1}), 32'h7);
        check("w1_busy_len", 32'(bc), 32'd1);
        op1(1'b1, 1'b0, 1'b0, s1, c1, bc, gd);
        check("w1_100", 32'({gd, c1, s1}), 32'h5);

        // Random cross-check, WIDTH=8, plus subtractor round-trip
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + 9'(rc);
            op8(ra, rb, rc, s8, c8, bc, gd);
            check("rnd8", 32'({gd, c8, s8}), 32'({1'b1, exp9}));
            diff = ra - rb;
            op8(diff, rb, 1'b0, s8, c8, bc, gd);
            check("rnd8_sub", 32'({gd, s8}), 32'({1'b1, ra}));
        end

        // Random cross-check, WIDTH=1
        for (int i = 0; i < 1000; i++) begin
            ra[0] = 1'($urandom); rb[0] = 1'($urandom); rc = 1'($urandom);
            exp2 = {1'b0, ra[0]} + {1'b0, rb[0]} + 2'(rc);
            op1(ra[0], rb[0], rc, s1, c1, bc, gd);
            check("rnd1", 32'({gd, c1, s1}), 32'({1'b1, exp2}));
            op1(ra[0] ^ rb[0], rb[0], 1'b0, s1, c1, bc, gd);
            check("rnd1_sub", 32'({gd, s1}), 32'({1'b1, ra[0]}));
        end

        check("busy_done_exclusive", 32'(overlap), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
